// File: rtl/rob_commit.sv
// rob_commit: in-order retirement at the ROB head; keeps the retirement RAT, frees superseded tags,
// and on a mispredicted head flushes the pipeline and redirects fetch. COMMIT_STATS_EN adds counters.
module rob_commit #(
  parameter int PHYSREGS_DEPTH  = 6,
  parameter int ARCHREGS_DEPTH  = 5,
  parameter int ROB_ENTRY_WIDTH = 35 + ARCHREGS_DEPTH + PHYSREGS_DEPTH
) (
  input  logic                                              CLK,
  input  logic                                              RESET,
  input  logic                                              FREEZE,
  input  logic                                              fROB_empty_IN,
  input  logic [ROB_ENTRY_WIDTH-1:0]                        fROB_headData_IN,
  output logic                                              tROB_popReq_OUT,
  output logic                                              tROB_flush_OUT,
  input  logic                                              fFreeL_full_IN,
  output logic                                              tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]                         tFreeL_pushData_OUT,
  output logic                                              tRenRatOverwrite_OUT,
  output logic [(1<<ARCHREGS_DEPTH)*PHYSREGS_DEPTH-1:0]     tRenRatOverwriteData_OUT,
  output logic                                              tFlush_OUT,
  output logic [31:0]                                       tRedirectPC_OUT,
  output logic [31:0]                                       fCommitCount_OUT,
  output logic [31:0]                                       fFlushCount_OUT
);
  localparam int P = PHYSREGS_DEPTH;
  localparam int A = ARCHREGS_DEPTH;
  localparam int NREGS = 1 << A;
  typedef enum logic [1:0] {RUN, FLUSH, RESUME} state_t;
  state_t         state_q;
  logic [P-1:0]   rat_q [NREGS];
  logic           push_req_q;
  logic [P-1:0]   push_data_q;
  logic           flush_q;
  logic [31:0]    redirect_q;
  logic           head_done, head_dreq, head_mispred, arch_nz, commit;
  logic [A-1:0]   head_arch;
  logic [P-1:0]   head_phys, free_tag;
  logic [31:0]    head_target;
  always_comb begin
    head_done    = fROB_headData_IN[0];
    head_dreq    = fROB_headData_IN[1];
    head_arch    = fROB_headData_IN[2 +: A];
    head_phys    = fROB_headData_IN[2+A +: P];
    head_mispred = fROB_headData_IN[2+A+P];
    head_target  = fROB_headData_IN[3+A+P +: 32];
    arch_nz      = head_arch != '0;
    // arch reg 0 is hardwired: its tag goes straight back, so a full freelist never blocks it
    commit       = state_q == RUN && !FREEZE && !fROB_empty_IN && head_done &&
                   !(head_dreq && arch_nz && fFreeL_full_IN);
    free_tag     = arch_nz ? rat_q[head_arch] : head_phys;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= RUN;
      for (int i = 0; i < NREGS; i++) rat_q[i] <= P'(i);
      push_req_q  <= 1'b0;
      push_data_q <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      push_req_q <= commit && head_dreq;
      if (commit && head_dreq) push_data_q <= free_tag;
      if (commit && head_dreq && arch_nz) rat_q[head_arch] <= head_phys;
      if (commit && head_mispred) begin
        state_q    <= FLUSH;
        flush_q    <= 1'b1;
        redirect_q <= head_target;
      end else if (!FREEZE && state_q == FLUSH) begin
        state_q <= RESUME;
        flush_q <= 1'b0;
      end else if (!FREEZE && state_q == RESUME) begin
        state_q <= RUN;
      end
    end
  end
  for (genvar g = 0; g < NREGS; g++) begin : g_ovw
    assign tRenRatOverwriteData_OUT[g*P +: P] = rat_q[g];
  end
  assign tROB_popReq_OUT      = commit;
  assign tROB_flush_OUT       = flush_q;
  assign tFlush_OUT           = flush_q;
  assign tRenRatOverwrite_OUT = flush_q;
  assign tFreeL_pushReq_OUT   = push_req_q;
  assign tFreeL_pushData_OUT  = push_data_q;
  assign tRedirectPC_OUT      = redirect_q;
`ifdef COMMIT_STATS_EN
  logic [31:0] commit_cnt_q, commit_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    commit_cnt_d = commit_cnt_q + 32'(commit);
    flush_cnt_d  = flush_cnt_q + 32'(commit && head_mispred);
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      commit_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign fCommitCount_OUT = commit_cnt_q;
  assign fFlushCount_OUT  = flush_cnt_q;
`else
  assign fCommitCount_OUT = '0;
  assign fFlushCount_OUT  = '0;
`endif
endmodule
